// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//   Bundles the two requester ports (CPU and DMA/loader), their grant/done
//   returns, and the memory-side bus of the arbiter.
//   modport slave  : the arbiter. Requests and data_bus_in come in; grants,
//                    done pulses, rdata and the memory strobes/bus go out.
//   modport master : the surrounding system (requesters plus memory), which
//                    is the mirror image of the slave modport.
interface mem_arbiter_if;
  // CPU requester
  logic       cpu_req;
  logic       cpu_wr;
  logic [5:0] cpu_adr;
  logic [7:0] cpu_wdata;
  logic       cpu_gnt;
  logic       cpu_done;
  // DMA / loader requester
  logic       dma_req;
  logic       dma_wr;
  logic [5:0] dma_adr;
  logic [7:0] dma_wdata;
  logic       dma_gnt;
  logic       dma_done;
  // read data returned to whichever requester was granted
  logic [7:0] rdata;
  // memory side
  logic [5:0] adr_bus;
  logic       rd_mem;
  logic       wr_mem;
  logic [7:0] data_bus_out;
  logic [7:0] data_bus_in;

  modport slave (
    input  cpu_req, cpu_wr, cpu_adr, cpu_wdata,
    input  dma_req, dma_wr, dma_adr, dma_wdata,
    input  data_bus_in,
    output cpu_gnt, cpu_done, dma_gnt, dma_done,
    output rdata, adr_bus, rd_mem, wr_mem, data_bus_out
  );

  modport master (
    output cpu_req, cpu_wr, cpu_adr, cpu_wdata,
    output dma_req, dma_wr, dma_adr, dma_wdata,
    output data_bus_in,
    input  cpu_gnt, cpu_done, dma_gnt, dma_done,
    input  rdata, adr_bus, rd_mem, wr_mem, data_bus_out
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Two-requester (CPU, DMA) arbiter in front of a single-ported memory.
//   One access at a time: IDLE -> ACCESS (MEM_LAT cycles of rd_mem/wr_mem)
//   -> DONE (one-cycle done pulse) -> IDLE. Contention is resolved
//   round-robin against the requester granted last; after reset the DMA
//   counts as "granted last", so the CPU wins the first contended round.
//   Every output is a flop.
// Ports
//   clk   : sole clock, rising edge
//   reset : synchronous, active-high
//   bus   : mem_arbiter_if.slave (requester inputs, gnt/done/rdata,
//           memory address/strobes/write data, memory read data)
// Parameter
//   MEM_LAT : cycles the strobe is held per access, 1..4
module mem_arbiter #(
  parameter int MEM_LAT = 1
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ACCESS   = 2'd1;
  localparam logic [1:0] DONE     = 2'd2;
  localparam logic [1:0] LAST_CNT = 2'(MEM_LAT - 1);

  logic [1:0] state;
  logic [1:0] cnt;
  logic       last_dma;

  logic       cpu_gnt;
  logic       dma_gnt;
  logic       cpu_done;
  logic       dma_done;
  logic       rd_mem;
  logic       wr_mem;
  logic [5:0] adr_bus;
  logic [7:0] data_bus_out;
  logic [7:0] rdata;

  logic       any_req;
  logic       pick_dma;
  logic       win_wr;
  logic [5:0] win_adr;
  logic [7:0] win_wdata;

  // Winner selection for the IDLE cycle. A lone request wins outright;
  // with both pending, the requester that was not granted last wins.
  always_comb begin
    any_req  = bus.cpu_req | bus.dma_req;
    pick_dma = bus.dma_req;
    if (bus.cpu_req && bus.dma_req) begin
      pick_dma = ~last_dma;
    end
    win_wr    = pick_dma ? bus.dma_wr    : bus.cpu_wr;
    win_adr   = pick_dma ? bus.dma_adr   : bus.cpu_adr;
    win_wdata = pick_dma ? bus.dma_wdata : bus.cpu_wdata;
  end

  // The strobe/address/data flops double as the latched copy of the
  // winner's request: they are loaded at the grant edge and held untouched
  // for the whole ACCESS phase, so requester inputs are ignored until IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= 2'd0;
      last_dma     <= 1'b1;
      cpu_gnt      <= 1'b0;
      dma_gnt      <= 1'b0;
      cpu_done     <= 1'b0;
      dma_done     <= 1'b0;
      rd_mem       <= 1'b0;
      wr_mem       <= 1'b0;
      adr_bus      <= 6'd0;
      data_bus_out <= 8'd0;
      rdata        <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state        <= ACCESS;
            cnt          <= 2'd0;
            last_dma     <= pick_dma;
            cpu_gnt      <= ~pick_dma;
            dma_gnt      <= pick_dma;
            rd_mem       <= ~win_wr;
            wr_mem       <= win_wr;
            adr_bus      <= win_adr;
            data_bus_out <= win_wr ? win_wdata : 8'd0;
          end
        end

        ACCESS: begin
          if (cnt == LAST_CNT) begin
            // Edge ending the last strobe cycle: memory read data is valid
            // now, so this is the only capture point for rdata.
            state        <= DONE;
            rd_mem       <= 1'b0;
            wr_mem       <= 1'b0;
            adr_bus      <= 6'd0;
            data_bus_out <= 8'd0;
            cpu_done     <= cpu_gnt;
            dma_done     <= dma_gnt;
            if (rd_mem) begin
              rdata <= bus.data_bus_in;
            end
          end else begin
            cnt <= cnt + 2'd1;
          end
        end

        DONE: begin
          // Unconditional return; a request still held is re-arbitrated
          // from IDLE on the following edge.
          state    <= IDLE;
          cpu_gnt  <= 1'b0;
          dma_gnt  <= 1'b0;
          cpu_done <= 1'b0;
          dma_done <= 1'b0;
        end

        default: begin
          state        <= IDLE;
          cpu_gnt      <= 1'b0;
          dma_gnt      <= 1'b0;
          cpu_done     <= 1'b0;
          dma_done     <= 1'b0;
          rd_mem       <= 1'b0;
          wr_mem       <= 1'b0;
          adr_bus      <= 6'd0;
          data_bus_out <= 8'd0;
        end
      endcase
    end
  end

  assign bus.cpu_gnt      = cpu_gnt;
  assign bus.dma_gnt      = dma_gnt;
  assign bus.cpu_done     = cpu_done;
  assign bus.dma_done     = dma_done;
  assign bus.rd_mem       = rd_mem;
  assign bus.wr_mem       = wr_mem;
  assign bus.adr_bus      = adr_bus;
  assign bus.data_bus_out = data_bus_out;
  assign bus.rdata        = rdata;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 1, meaning: number of cycles (1-4) rd_mem/wr_mem stay asserted per access.
REQ-002 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port reset  input  1  synchronous, active-high reset.
REQ-004 Port cpu_req  input  1  CPU requests one memory access; held until cpu_done.
REQ-005 Port cpu_wr  input  1  CPU access type: 1 write, 0 read.
REQ-006 Port cpu_adr  input  6  CPU word address.
REQ-007 Port cpu_wdata  input  8  CPU write data.
REQ-008 Port dma_req, dma_wr, dma_adr, dma_wdata  input  1/1/6/8  DMA/loader requester, same meaning as CPU set.
REQ-009 Port cpu_gnt, dma_gnt  output  1 each  high for the full ACCESS and DONE phases of that requester's access.
REQ-010 Port cpu_done, dma_done  output  1 each  one-cycle completion pulse.
REQ-011 Port rdata  output  8  read data returned to the granted requester; valid while its done is high.
REQ-012 Port adr_bus  output  6  memory address.
REQ-013 Port rd_mem, wr_mem  output  1 each  memory read/write strobes.
REQ-014 Port data_bus_out  output  8  memory write data.
REQ-015 Port data_bus_in  input  8  memory read data, valid during the last strobe cycle.

Function
REQ-016 FSM states SHALL be IDLE, ACCESS, DONE; all outputs SHALL be registered.
REQ-017 IDLE: with no req, stay IDLE; with exactly one req, grant it; with both, grant the requester not granted last (round-robin).
REQ-018 On grant, the arbiter SHALL latch the winner's wr/adr/wdata at that edge; requester inputs are ignored afterwards until IDLE.
REQ-019 ACCESS SHALL last exactly MEM_LAT cycles, driving adr_bus, data_bus_out (writes only; 0 for reads), and rd_mem (read) or wr_mem (write), never both.
REQ-020 For reads, rdata SHALL capture data_bus_in at the edge ending the last ACCESS cycle.
REQ-021 DONE SHALL last one cycle: strobes low, winner's done high, then unconditional return to IDLE.
REQ-022 Latency: req sampled in IDLE at edge E0 -> strobes in cycles 1..MEM_LAT -> done in cycle MEM_LAT+1 -> IDLE in cycle MEM_LAT+2.
REQ-023 A req deasserted during ACCESS SHALL NOT abort the access; it completes and done still pulses.
REQ-024 A req still high in IDLE after its done SHALL be treated as a new request (subject to round-robin).
REQ-025 The last-granted pointer SHALL update on each grant only.
REQ-026 At most one gnt and at most one done SHALL be high in any cycle.
REQ-027 adr_bus and data_bus_out SHALL be 0 outside ACCESS; rdata SHALL hold its value until the next read capture.
REQ-028 MEM_LAT outside 1-4 is unsupported; no runtime checking required.

Reset
REQ-029 On reset at a clock edge, state SHALL go to IDLE and gnt, done, rd_mem, wr_mem, adr_bus, data_bus_out, rdata SHALL all be 0.
REQ-030 Reset SHALL set the last-granted pointer to DMA, so CPU wins the first contended arbitration.
REQ-031 Reset during ACCESS or DONE SHALL abort the access with no done pulse; strobes are low in the cycle after the reset edge.

Verification
REQ-032 MEM_LAT=1, CPU read adr 0x05, data_bus_in=0xA7 -> rd_mem high cycle 1 with adr_bus=0x05; cpu_done and rdata=0xA7 in cycle 2.
REQ-033 MEM_LAT=2, DMA write adr 0x3F data 0x5C -> wr_mem high cycles 1-2, adr_bus=0x3F, data_bus_out=0x5C; dma_done cycle 3; rd_mem never high.
REQ-034 Both req high from reset, held continuously -> grant sequence CPU, DMA, CPU, DMA; never two grants in overlapping windows.
REQ-035 CPU req dropped mid-ACCESS (MEM_LAT=3) -> access completes, cpu_done pulses in cycle 4.
REQ-036 Reset asserted in cycle 1 of a DMA write -> wr_mem low the next cycle, no dma_done, subsequent contended request granted to CPU.
REQ-037 Requester inputs changed during ACCESS (adr 0x01 -> 0x22) -> adr_bus stays 0x01 until access ends.
